// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller takes the slave side: it reads Op and drives every control line.
interface main_control_fsm_if #(
  parameter int op_width    = 6,
  parameter int ALUOp_width = 2,
  parameter int state_width = 4
);
  logic [op_width-1:0]    Op;
  logic                   IorD;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [ALUOp_width-1:0] ALUOp;
  logic [1:0]             PCSrc;
  logic                   RegDst;
  logic                   MemtoReg;
  logic                   IRWrite;
  logic                   PCWrite;
  logic                   Branch;
  logic                   MemWrite;
  logic                   RegWrite;
  logic [state_width-1:0] state;

  modport master (
    output Op,
    input  IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc, RegDst, MemtoReg,
           IRWrite, PCWrite, Branch, MemWrite, RegWrite, state
  );

  modport slave (
    input  Op,
    output IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc, RegDst, MemtoReg,
           IRWrite, PCWrite, Branch, MemWrite, RegWrite, state
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM that turns the opcode into per-cycle
// datapath selects, write strobes and the ALUOp handed to the ALU control unit.
module main_control_fsm #(
  parameter int op_width    = 6,
  parameter int ALUOp_width = 2,
  parameter int state_width = 4
) (
  input  logic              clk,
  input  logic              reset,
  main_control_fsm_if.slave bus
);

  localparam logic [op_width-1:0] OP_R    = op_width'(6'b000000);
  localparam logic [op_width-1:0] OP_LW   = op_width'(6'b100011);
  localparam logic [op_width-1:0] OP_SW   = op_width'(6'b101011);
  localparam logic [op_width-1:0] OP_BEQ  = op_width'(6'b000100);
  localparam logic [op_width-1:0] OP_ADDI = op_width'(6'b001000);
  localparam logic [op_width-1:0] OP_J    = op_width'(6'b000010);

  localparam logic [ALUOp_width-1:0] ALU_ADD   = ALUOp_width'(2'b00);
  localparam logic [ALUOp_width-1:0] ALU_SUB   = ALUOp_width'(2'b01);
  localparam logic [ALUOp_width-1:0] ALU_FUNCT = ALUOp_width'(2'b10);

  typedef enum logic [state_width-1:0] {
    S_FETCH  = state_width'(0),
    S_DECODE = state_width'(1),
    S_MEMADR = state_width'(2),
    S_MEMRD  = state_width'(3),
    S_MEMWB  = state_width'(4),
    S_MEMWR  = state_width'(5),
    S_EXEC   = state_width'(6),
    S_ALUWB  = state_width'(7),
    S_BRANCH = state_width'(8),
    S_ADDIEX = state_width'(9),
    S_ADDIWB = state_width'(10),
    S_JUMP   = state_width'(11)
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_dec_state;

  logic                   w_IorD, w_ALUSrcA, w_RegDst, w_MemtoReg;
  logic                   w_IRWrite, w_PCWrite, w_Branch, w_MemWrite, w_RegWrite;
  logic [1:0]             w_ALUSrcB, w_PCSrc;
  logic [ALUOp_width-1:0] w_ALUOp;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Op is only consulted in DECODE and MEMADR; everywhere else the path is fixed.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (bus.Op)
          OP_LW:   w_next = S_MEMRD;
          OP_SW:   w_next = S_MEMWR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // During reset the selects already present FETCH values; strobes are masked below.
  assign w_dec_state = reset ? S_FETCH : r_state;

  always_comb begin
    w_IorD     = 1'b0;
    w_ALUSrcA  = 1'b0;
    w_ALUSrcB  = 2'b00;
    w_ALUOp    = ALU_ADD;
    w_PCSrc    = 2'b00;
    w_RegDst   = 1'b0;
    w_MemtoReg = 1'b0;
    w_IRWrite  = 1'b0;
    w_PCWrite  = 1'b0;
    w_Branch   = 1'b0;
    w_MemWrite = 1'b0;
    w_RegWrite = 1'b0;
    case (w_dec_state)
      S_FETCH:  begin w_ALUSrcB = 2'b01; w_IRWrite = 1'b1; w_PCWrite = 1'b1; end
      S_DECODE: w_ALUSrcB = 2'b11;
      S_MEMADR: begin w_ALUSrcA = 1'b1; w_ALUSrcB = 2'b10; end
      S_MEMRD:  w_IorD = 1'b1;
      S_MEMWB:  begin w_MemtoReg = 1'b1; w_RegWrite = 1'b1; end
      S_MEMWR:  begin w_IorD = 1'b1; w_MemWrite = 1'b1; end
      S_EXEC:   begin w_ALUSrcA = 1'b1; w_ALUOp = ALU_FUNCT; end
      S_ALUWB:  begin w_RegDst = 1'b1; w_RegWrite = 1'b1; end
      S_BRANCH: begin w_ALUSrcA = 1'b1; w_ALUOp = ALU_SUB; w_PCSrc = 2'b01; w_Branch = 1'b1; end
      S_ADDIEX: begin w_ALUSrcA = 1'b1; w_ALUSrcB = 2'b10; end
      S_ADDIWB: w_RegWrite = 1'b1;
      S_JUMP:   begin w_PCSrc = 2'b10; w_PCWrite = 1'b1; end
      default:  ;
    endcase
    if (reset) begin
      w_IRWrite  = 1'b0;
      w_PCWrite  = 1'b0;
      w_Branch   = 1'b0;
      w_MemWrite = 1'b0;
      w_RegWrite = 1'b0;
    end
  end

  assign bus.IorD     = w_IorD;
  assign bus.ALUSrcA  = w_ALUSrcA;
  assign bus.ALUSrcB  = w_ALUSrcB;
  assign bus.ALUOp    = w_ALUOp;
  assign bus.PCSrc    = w_PCSrc;
  assign bus.RegDst   = w_RegDst;
  assign bus.MemtoReg = w_MemtoReg;
  assign bus.IRWrite  = w_IRWrite;
  assign bus.PCWrite  = w_PCWrite;
  assign bus.Branch   = w_Branch;
  assign bus.MemWrite = w_MemWrite;
  assign bus.RegWrite = w_RegWrite;
  assign bus.state    = r_state;

endmodule
